// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: sweeps a 2-input gate through Gray-ordered vectors and captures its truth table.
// Optional self-check (expected_tt/pass) is enabled with GATE_SWEEP_CHECK_EN.
module gate_sweep_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       gate_out,
    output logic       in_1,
    output logic       in_2,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table
`ifdef GATE_SWEEP_CHECK_EN
    ,
    input  logic [3:0] expected_tt,
    output logic       pass
`endif
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d, vec_q, vec_d, idx_nx;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [3:0]  tt_q, tt_d;
    logic        pass_q, pass_d;
    logic        last;
    logic [3:0]  exp_tt;
`ifdef GATE_SWEEP_CHECK_EN
    assign exp_tt = expected_tt;
    assign pass   = pass_q;
`else
    assign exp_tt = 4'b0000;
`endif
    assign idx_nx = idx_q + 2'd1;
    assign last   = cnt_q == 8'(DWELL - 1);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tt_d    = tt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = APPLY;
                idx_d   = 2'd0;
                cnt_d   = 8'd0;
                vec_d   = 2'b00;
                busy_d  = 1'b1;
                tt_d    = 4'b0000;
                pass_d  = 1'b0;
            end
            APPLY: if (last) begin
                tt_d[vec_q] = gate_out;
                cnt_d       = 8'd0;
                idx_d       = idx_nx;
                vec_d       = {idx_nx[1], idx_nx[1] ^ idx_nx[0]};
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    vec_d   = 2'b00;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = tt_d == exp_tt;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            vec_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= 4'b0000;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
        end
    end
    assign {in_1, in_2} = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign truth_table  = tt_q;
endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter DWELL, default 4, cycles each input vector is held before sampling; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle sweep request; sampled only in IDLE.
REQ-005 gate_out  input  1  output of the 2-input gate under control.
REQ-006 in_1  output  1  first gate input driven by the sweep.
REQ-007 in_2  output  1  second gate input driven by the sweep.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse when a sweep completes.
REQ-010 truth_table  output  4  captured gate response; bit index = {in_1,in_2}.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, APPLY, DONE.
REQ-012 In IDLE, start=1 at cycle t SHALL clear truth_table, set the vector index to 0 and the dwell counter to 0, and enter APPLY at t+1.
REQ-013 Vector order SHALL be index 0..3 = {in_1,in_2} 00, 01, 11, 10 (Gray order); in_1/in_2 SHALL be registered outputs equal to the current vector while in APPLY.
REQ-014 In APPLY the dwell counter SHALL increment each cycle; when it equals DWELL-1, gate_out SHALL be written into truth_table[{in_1,in_2}], the counter reset to 0, and the index advanced.
REQ-015 After the index-3 sample, the FSM SHALL enter DONE, so done is high at cycle t+1+4*DWELL.
REQ-016 busy SHALL be 1 exactly in APPLY (4*DWELL cycles per sweep).
REQ-017 DONE SHALL last one cycle, with done=1, busy=0, in_1=in_2=0, and SHALL return to IDLE.
REQ-018 start in APPLY or DONE SHALL be ignored, with no queuing.
REQ-019 truth_table SHALL hold its value from DONE until the next accepted start.
REQ-020 In IDLE, in_1 and in_2 SHALL be 0.
REQ-021 The dwell counter SHALL be 8 bits and SHALL never exceed DWELL-1; with DWELL=1, every APPLY cycle samples and advances.

Reset
REQ-022 reset=1 SHALL, on the next edge, force IDLE with busy=0, done=0, in_1=0, in_2=0, truth_table=0, index=0 and counter=0.
REQ-023 reset SHALL take priority over start and over any in-progress sweep; a sweep interrupted by reset SHALL NOT produce done.

Configuration
REQ-024 With macro GATE_SWEEP_CHECK_EN defined, the block SHALL add the input expected_tt[3:0] and the output pass (1 bit), and SHALL register pass = (final truth_table == expected_tt) in the DONE cycle.
REQ-025 With GATE_SWEEP_CHECK_EN defined, pass SHALL hold its value until the next accepted start or reset, both of which clear it to 0.
REQ-026 Without GATE_SWEEP_CHECK_EN, the block SHALL omit expected_tt and pass, and all other behaviour SHALL be identical.

Verification
REQ-027 AND gate, DWELL=4, start at cycle 0 -> busy cycles 1-16; in_1/in_2 sequence 00,01,11,10 every 4 cycles; done at cycle 17; truth_table=4'b1000.
REQ-028 OR gate, DWELL=4 -> truth_table=4'b1110; XOR gate -> 4'b0110; DWELL=1 with XOR -> done at cycle 5, truth_table=4'b0110.
REQ-029 Start pulses at cycles 3 and 17 during a sweep -> ignored; exactly one done pulse; a start at cycle 18 (IDLE) begins a new sweep with truth_table cleared.
REQ-030 reset asserted at cycle 9 mid-sweep -> outputs all 0 at cycle 10; no done pulse; a later start runs a full sweep correctly.
REQ-031 GATE_SWEEP_CHECK_EN build, AND gate: expected_tt=4'b1000 -> pass=1 at done; expected_tt=4'b1110 -> pass=0.
